uart_fifo: RTL and testbench
============================

# uart_fifo

Buffered, parametrised successor to the system UART: a 16-bit 68000-style bus slave with independent TX and RX FIFOs, a programmable bit period, and 8N1 serial framing. It sits on the CPU peripheral bus next to the memory controller. It also serves as the bench-side serial partner in the top-level simulation, replacing byte-at-a-time polling with queued transfers.

## Interface

- `CLK_DIV`, default 217: clock cycles per serial bit, minimum 4.
- `DEPTH_LOG2`, default 4: each FIFO holds 2^DEPTH_LOG2 bytes.
- `clk` in, 1 bit: single clock; all logic runs on its rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `rx` in, 1 bit: serial input, asynchronous; idles high.
- `tx` out, 1 bit: serial output; idles high.
- `addr` in, 2 bits: register select; 0 is DATA, 1 is STATUS, 2 is CTRL, 3 is reserved.
- `rw` in, 1 bit: 1 for read, 0 for write.
- `uds` in, 1 bit: upper-byte strobe, active-high.
- `lds` in, 1 bit: lower-byte strobe, active-high.
- `data_write` in, 16 bits: write data.
- `data_read` out, 16 bits: read data.
- `rx_avail` out, 1 bit: RX FIFO is not empty.
- `tx_active` out, 1 bit: TX FIFO is not empty, or the shifter is not IDLE.

## Operation

**Bus access**
- An access fires on the cycle where (`uds`|`lds`) is 1 and was 0 on the previous cycle. A strobe held high performs exactly one access.
- `data_read` is combinational from `addr` and the current state. Pop side effects apply at the clock edge of the firing cycle.

**DATA register (addr 0)**
- Write with `uds`: pushes `data_write[15:8]` into the TX FIFO.
- Write while the TX FIFO is full: the byte is dropped and `tx_ovf` is set.
- Read: `data_read` = {RX head, 8'h00}. A firing read pops the RX FIFO.
- Read while the RX FIFO is empty: returns 16'h0000 and does not pop.

**STATUS register (addr 1)**
- Read: `data_read[7:0]` = {`frame_err`, `tx_ovf`, `rx_ovf`, `tx_active`, `tx_empty`, `tx_full`, `rx_full`, `rx_avail`}. `data_read[15:8]` = RX FIFO count, zero-extended.
- Write with `lds`: each 1 in `data_write[7:5]` clears the matching sticky bit (write-1-to-clear).

**CTRL register (addr 2)**
- Bit 0 is loopback; see Configuration. All other bits read 0.

**Reserved (addr 3)**
- Reads 0; writes are ignored.

**FIFOs**
- Both FIFOs are circular buffers with DEPTH_LOG2-bit pointers that wrap modulo depth, plus a count of DEPTH_LOG2+1 bits.
- A push and a pop in the same cycle both take effect and leave the count unchanged.
- A push to a full FIFO is accepted if a pop happens in the same cycle.

**TX state machine (IDLE → START → DATA → STOP → IDLE)**
- IDLE with a non-empty FIFO: pop into the shift register and go to START on the next edge.
- START drives 0, DATA drives 8 bits LSB first, STOP drives 1. Each bit lasts `CLK_DIV` cycles.
- At the end of STOP the machine returns to IDLE and reloads in the next cycle if data is present.

**RX state machine (IDLE → START → DATA → STOP → IDLE)**
- `rx` passes through a 2-flop synchroniser before use.
- IDLE: a synchronised low moves to START.
- START: wait `CLK_DIV/2` cycles, then re-check. If the line is high (a glitch), return to IDLE.
- DATA: sample 8 bits LSB first, one every `CLK_DIV` cycles.
- STOP: sample mid-bit.
  - Stop bit 1: push the byte. If the FIFO is full, drop the byte and set `rx_ovf`.
  - Stop bit 0: discard the byte and set `frame_err`.
- After the stop sample, go straight to IDLE.

## Timing

**Reset**
- Values after reset: `tx`=1, `data_read` reflects empty state, `rx_avail`=0, `tx_active`=0.
- Reset empties both FIFOs, clears all sticky bits and CTRL, and returns both state machines to IDLE.
- Reset mid-frame aborts the frame at the next edge; `tx` is high on the following cycle.

**Latency**
- A DATA write edge on an idle block leads to the `tx` start bit 2 cycles later: 1 cycle for the push, 1 cycle for the load.
- One frame lasts `10*CLK_DIV` cycles.
- From the mid-stop-bit sample to `rx_avail`=1 is 1 cycle.
- Synchroniser delay is 2 cycles; the sample point is `CLK_DIV/2` after the detected falling edge, ±2 cycles.

**Back-to-back operation**
- Queued TX bytes leave with exactly 1 idle cycle between the stop bit and the next start bit.

## Configuration

`UART_FIFO_LOOPBACK_EN`:
- **Defined:** CTRL bit 0 is read/write.
  - When it is 1, the RX synchroniser input is internal `tx` instead of the `rx` pin.
  - The `tx` pin is held at 1 while loopback is set.
- **Undefined:** CTRL bit 0 reads 0, writes are ignored, and `rx` is always the pin.

## Test plan

- **Reset:** hold `reset` for 3 cycles, then read STATUS → 16'h0008 and `tx`=1.
- **Back-to-back TX:** write 0x41, 0x42, 0x43 to DATA → three 8N1 frames at `CLK_DIV`=217 with 1 idle cycle between them, and `tx_active` falls 1 cycle after the last stop bit.
- **RX overflow:** drive 17 frames into `rx` with `DEPTH_LOG2`=4 and no reads → STATUS[15:8]=16, `rx_full`=1, `rx_ovf`=1. Then 16 DATA reads return the first 16 bytes in order, and the 17th read returns 0.
- **Framing error and clear:** send 0x55 with stop bit 0 → `frame_err`=1 and no push. A STATUS write of 16'h0080 clears it.
- **Held strobe and simultaneous full push/pop:** hold `uds` high for 5 cycles on a DATA read → exactly 1 pop. An RX push coinciding with a pop while the FIFO is full → count stays 16 and `rx_ovf` stays 0.
- **Loopback (macro defined):** set CTRL=1, write 0xA5 → after 10 bit periods DATA reads 16'hA500, and the `tx` pin stays 1 throughout.

Source files
------------

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - buffered 8N1 UART bus slave with TX/RX FIFOs; optional loopback under UART_FIFO_LOOPBACK_EN

module uart_fifo_buf #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty,
    output logic                dropped
);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign rdata   = mem[rd_ptr];

    // Storage write, kept free of reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap at the depth; count moves only on an unbalanced push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

module uart_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    input  logic [1:0]  addr,
    input  logic        rw,
    input  logic        uds,
    input  logic        lds,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        rx_avail,
    output logic        tx_active
);
    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic                strobe_q, fire;
    logic                wr_data, rd_data, wr_status;
    logic                frame_err, tx_ovf, rx_ovf, loopback;
    logic [7:0]          tx_head, rx_head;
    logic [DEPTH_LOG2:0] tx_count, rx_count;
    logic                tx_full, tx_empty, tx_drop, rx_full, rx_empty, rx_drop;
    uart_state_t         tx_state, tx_next, rx_state, rx_next;
    logic [CW-1:0]       tx_cnt, rx_cnt;
    logic [2:0]          tx_bit, rx_bit;
    logic [7:0]          tx_shift, rx_shift;
    logic                tx_line, tx_bit_done, rx_bit_done, rx_half_done;
    logic                rx_s1, rx_s2, rx_push, rx_frame_bad;
    logic                unused_sink;

    assign unused_sink = ^{data_write[4:0], tx_count};

    // Access fires on the rising edge of the combined byte strobes
    always_ff @(posedge clk) begin
        strobe_q <= reset ? 1'b0 : (uds || lds);
    end

    assign fire      = (uds || lds) && !strobe_q;
    assign wr_data   = fire && !rw && (addr == 2'd0) && uds;
    assign rd_data   = fire && rw && (addr == 2'd0);
    assign wr_status = fire && !rw && (addr == 2'd1) && lds;

`ifdef UART_FIFO_LOOPBACK_EN
    // CTRL loopback bit
    always_ff @(posedge clk) begin
        if (reset) loopback <= 1'b0;
        else if (fire && !rw && (addr == 2'd2) && lds) loopback <= data_write[0];
    end
`else
    assign loopback = 1'b0;
`endif

    uart_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_data), .pop(tx_state == S_IDLE),
        .wdata(data_write[15:8]), .rdata(tx_head), .count(tx_count),
        .full(tx_full), .empty(tx_empty), .dropped(tx_drop)
    );

    uart_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rd_data),
        .wdata(rx_shift), .rdata(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty), .dropped(rx_drop)
    );

    // Sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            frame_err <= rx_frame_bad || (frame_err && !(wr_status && data_write[7]));
            tx_ovf    <= tx_drop      || (tx_ovf    && !(wr_status && data_write[6]));
            rx_ovf    <= rx_drop      || (rx_ovf    && !(wr_status && data_write[5]));
        end
    end

    assign rx_avail  = !rx_empty;
    assign tx_active = !tx_empty || (tx_state != S_IDLE);
    assign tx        = loopback ? 1'b1 : tx_line;

    // Register read mux; an empty RX FIFO reads as zero
    always_comb begin
        data_read = 16'h0000;
        case (addr)
            2'd0:    if (!rx_empty) data_read = {rx_head, 8'h00};
            2'd1:    data_read = {8'(rx_count), frame_err, tx_ovf, rx_ovf, tx_active,
                                  tx_empty, tx_full, rx_full, !rx_empty};
            2'd2:    data_read = {15'd0, loopback};
            default: data_read = 16'h0000;
        endcase
    end

    assign tx_bit_done = (tx_cnt == BIT_END);

    // TX state register
    always_ff @(posedge clk) begin
        tx_state <= reset ? S_IDLE : tx_next;
    end

    // TX next state
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (!tx_empty) tx_next = S_START;
            S_START: if (tx_bit_done) tx_next = S_DATA;
            S_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_bit_done) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // TX line level per state
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift[0];
            default: tx_line = 1'b1;
        endcase
    end

    // TX datapath: load the FIFO head while idle, shift LSB-first at each data bit end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_cnt <= (tx_state == S_IDLE || tx_bit_done) ? '0 : tx_cnt + 1'b1;
            if (tx_state == S_IDLE) begin
                tx_shift <= tx_head;
                tx_bit   <= '0;
            end else if (tx_state == S_DATA && tx_bit_done) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end
    end

    // RX synchroniser; resets high so reset release never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= loopback ? tx_line : rx;
            rx_s2 <= rx_s1;
        end
    end

    assign rx_bit_done  = (rx_cnt == BIT_END);
    assign rx_half_done = (rx_cnt == HALF_END);

    // RX state register
    always_ff @(posedge clk) begin
        rx_state <= reset ? S_IDLE : rx_next;
    end

    // RX next state; a start bit that is high again at mid-bit is a glitch
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rx_s2) rx_next = S_START;
            S_START: if (rx_half_done) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_bit_done && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_bit_done) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    // RX outputs at the mid-stop-bit sample
    always_comb begin
        rx_push      = 1'b0;
        rx_frame_bad = 1'b0;
        if (rx_state == S_STOP && rx_bit_done) begin
            rx_push      = rx_s2;
            rx_frame_bad = !rx_s2;
        end
    end

    // RX datapath: counter restarts at mid start bit so later samples land mid-bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == S_IDLE || (rx_state == S_START ? rx_half_done : rx_bit_done))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_IDLE) begin
                rx_bit <= '0;
            end else if (rx_state == S_DATA && rx_bit_done) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - randomized self-checking bench for uart_fifo against a queue-based model
`timescale 1ns/1ps
module tb_uart_fifo;
    localparam int CLK_DIV = 217;
    localparam int DEPTH   = 16;
    localparam int FRAME   = 10 * CLK_DIV;
    localparam int SLOT    = FRAME + 1;
    localparam int NCAP    = 3 * SLOT;

    logic        clk = 1'b0;
    logic        reset, rx, tx, rw, uds, lds, rx_avail, tx_active;
    logic [1:0]  addr;
    logic [15:0] data_write, data_read;

    int total = 0;
    int bad   = 0;

    logic [7:0] rxq[$];
    bit         m_frame_err, m_tx_ovf, m_rx_ovf, m_tx_act;
    int         m_tx_cnt;

    logic       wave [NCAP];
    logic       act  [NCAP];

    uart_fifo #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .addr(addr), .rw(rw),
        .uds(uds), .lds(lds), .data_write(data_write), .data_read(data_read),
        .rx_avail(rx_avail), .tx_active(tx_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_status();
        int n;
        n = rxq.size();
        return {8'(n), m_frame_err, m_tx_ovf, m_rx_ovf, m_tx_act,
                (m_tx_cnt == 0), (m_tx_cnt == DEPTH), (n == DEPTH), (n != 0)};
    endfunction

    task automatic model_rx(input logic [7:0] b, input logic stop);
        if (!stop) m_frame_err = 1'b1;
        else if (rxq.size() < DEPTH) rxq.push_back(b);
        else m_rx_ovf = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic u, input logic l);
        addr = a; rw = 1'b0; data_write = d; uds = u; lds = l;
        @(negedge clk);
        uds = 1'b0; lds = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] v);
        addr = a; rw = 1'b1; lds = 1'b1;
        #1 v = data_read;
        @(negedge clk);
        lds = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  b, txb[3];
        logic        st;
        int          d, errs;

        reset = 1'b1; rx = 1'b1; addr = '0; rw = 1'b1; uds = 1'b0; lds = 1'b0; data_write = '0;
        m_frame_err = 0; m_tx_ovf = 0; m_rx_ovf = 0; m_tx_act = 0; m_tx_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_tx", tx, 1'b1);
        check("reset_rx_avail", rx_avail, 1'b0);
        check("reset_tx_active", tx_active, 1'b0);
        bus_read(2'd1, v); check("reset_status", v, 16'h0008);
        bus_read(2'd0, v); check("empty_data_read", v, 16'h0000);
        bus_write(2'd3, 16'hFFFF, 1'b1, 1'b1);
        bus_read(2'd3, v); check("reserved_read", v, 16'h0000);
        bus_write(2'd0, 16'h5A5A, 1'b0, 1'b1);
        bus_read(2'd1, v); check("lds_data_write_ignored", v, model_status());
`ifndef UART_FIFO_LOOPBACK_EN
        bus_write(2'd2, 16'h0001, 1'b0, 1'b1);
        bus_read(2'd2, v); check("ctrl_reads_zero", v, 16'h0000);
`endif

        // back-to-back transmit
        txb[0] = 8'h41; txb[1] = 8'h42; txb[2] = 8'h43;
        addr = 2'd0; rw = 1'b0; data_write = {txb[0], 8'($urandom)}; uds = 1'b1;
        @(negedge clk);
        check("tx_before_load", tx, 1'b1);
        uds = 1'b0;
        @(negedge clk);
        check("tx_start_latency", tx, 1'b0);
        fork
            for (int i = 0; i < NCAP; i++) begin
                wave[i] = tx; act[i] = tx_active;
                @(negedge clk);
            end
            begin
                bus_write(2'd0, {txb[1], 8'($urandom)}, 1'b1, 1'b0);
                bus_write(2'd0, {txb[2], 8'($urandom)}, 1'b1, 1'b0);
            end
        join
        for (int f = 0; f < 3; f++) begin
            errs = 0;
            for (int c = 0; c < SLOT; c++) begin
                logic e;
                if (c < CLK_DIV) e = 1'b0;
                else if (c < 9 * CLK_DIV) e = txb[f][(c - CLK_DIV) / CLK_DIV];
                else e = 1'b1;
                if (wave[f * SLOT + c] !== e) errs++;
            end
            check($sformatf("tx_frame%0d_bad_cycles", f), errs, 0);
        end
        errs = 0;
        for (int i = 0; i < NCAP - 1; i++) if (act[i] !== 1'b1) errs++;
        check("tx_active_hold", errs, 0);
        check("tx_active_fall", act[NCAP - 1], 1'b0);
        bus_read(2'd1, v); check("tx_done_status", v, model_status());

        // TX overflow then reset mid-frame
        for (int i = 0; i < DEPTH + 2; i++) bus_write(2'd0, {8'($urandom), 8'h00}, 1'b1, 1'b0);
        m_tx_cnt = DEPTH; m_tx_ovf = 1; m_tx_act = 1;
        bus_read(2'd1, v); check("tx_ovf_status", v, model_status());
        bus_write(2'd1, 16'h0040, 1'b0, 1'b1);
        m_tx_ovf = 0;
        bus_read(2'd1, v); check("tx_ovf_clear", v, model_status());
        reset = 1'b1;
        @(negedge clk);
        check("reset_abort_tx", tx, 1'b1);
        check("reset_abort_active", tx_active, 1'b0);
        reset = 1'b0;
        m_tx_cnt = 0; m_tx_act = 0;
        bus_read(2'd1, v); check("post_abort_status", v, model_status());

        // RX latency calibration (first of 17 frames)
        b = 8'($urandom);
        d = 0;
        fork
            send_frame(b, 1'b1);
            begin : lat_watch
                int i;
                i = 0;
                while (d == 0 && i < 3000) begin
                    @(negedge clk);
                    i++;
                    if (rx_avail) d = i;
                end
            end
        join
        model_rx(b, 1'b1);
        check("rx_latency_window", (d >= 2062 && d <= 2066), 1'b1);
        if (d == 0) d = 2064;
        for (int k = 1; k < 17; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_rx(b, 1'b1);
        end
        bus_read(2'd1, v); check("rx_overflow_status", v, model_status());
        check("rx_avail_full", rx_avail, 1'b1);
        bus_write(2'd1, 16'h0020, 1'b0, 1'b1);
        m_rx_ovf = 0;
        bus_read(2'd1, v); check("rx_ovf_clear", v, model_status());

        // push into a full RX FIFO coinciding with a pop
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                logic [15:0] cv;
                repeat (d - 1) @(negedge clk);
                bus_read(2'd0, cv);
                check("coincide_data", cv, {rxq[0], 8'h00});
            end
        join
        void'(rxq.pop_front());
        model_rx(b, 1'b1);
        bus_read(2'd1, v); check("coincide_status", v, model_status());

        // held strobe: one pop only
        addr = 2'd0; rw = 1'b1; uds = 1'b1;
        #1 check("held_strobe_data", data_read, {rxq[0], 8'h00});
        repeat (5) @(negedge clk);
        uds = 1'b0;
        @(negedge clk);
        void'(rxq.pop_front());
        bus_read(2'd1, v); check("held_strobe_count", v, model_status());
        while (rxq.size() > 0) begin
            bus_read(2'd0, v);
            check("rx_drain", v, {rxq.pop_front(), 8'h00});
        end
        bus_read(2'd0, v); check("rx_read_empty", v, 16'h0000);
        bus_read(2'd1, v); check("rx_drained_status", v, model_status());

        // framing error and clear
        send_frame(8'h55, 1'b0);
        model_rx(8'h55, 1'b0);
        bus_read(2'd1, v); check("frame_err_status", v, model_status());
        bus_write(2'd1, 16'h0080, 1'b0, 1'b1);
        m_frame_err = 0;
        bus_read(2'd1, v); check("frame_err_clear", v, model_status());

        // start-bit glitch is ignored
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (11 * CLK_DIV) @(negedge clk);
        bus_read(2'd1, v); check("glitch_no_push", v, model_status());

        // random frames with occasional bad stop bits
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            send_frame(b, st);
            model_rx(b, st);
        end
        bus_read(2'd1, v); check("random_status", v, model_status());
        while (rxq.size() > 0) begin
            bus_read(2'd0, v);
            check("random_data", v, {rxq.pop_front(), 8'h00});
        end
        bus_write(2'd1, 16'h00E0, 1'b0, 1'b1);
        m_frame_err = 0;
        bus_read(2'd1, v); check("random_end_status", v, model_status());

`ifdef UART_FIFO_LOOPBACK_EN
        bus_write(2'd2, 16'h0001, 1'b0, 1'b1);
        bus_read(2'd2, v); check("ctrl_loopback_set", v, 16'h0001);
        bus_write(2'd0, 16'hA500, 1'b1, 1'b0);
        errs = 0;
        repeat (FRAME + 20) begin
            if (tx !== 1'b1) errs++;
            @(negedge clk);
        end
        check("loopback_tx_pin_high", errs, 0);
        bus_read(2'd0, v); check("loopback_data", v, 16'hA500);
        bus_write(2'd2, 16'h0000, 1'b0, 1'b1);
        bus_read(2'd1, v); check("loopback_end_status", v, model_status());
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
